shift_req_stage: RTL and testbench

SHIFT_REQ_STAGE -- requirements
Module: shift_req_stage

---
 rtl/shift_req_stage.sv | 188 ++++++++++++++++++
 tb/tb_shift_req_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_req_stage.sv
// ---------------------------------------------------------------------------
// shift_req_stage
//
// Request-queue front end for an external 8-bit logical-right barrel shifter.
// Incoming {data, amount} pairs are buffered in a small circular FIFO. The
// head entry is presented to the shifter combinationally, and the shifter's
// result is captured into an output register that uses a valid/ready
// handshake.
//
// Optional feature:
//   SHIFT_REQ_LOST_BITS_EN - when defined, out_lost reports whether any '1'
//                            bit was shifted off the low end of the operand.
//                            When undefined, out_lost is tied to 0 and no
//                            lost-bit logic is built.
//
// Parameters:
//   DEPTH       FIFO depth in entries (2, 4 or 8)
//
// Ports:
//   clk         single clock, rising-edge active
//   rst         asynchronous, active-high reset
//   in_valid    upstream request valid
//   in_ready    stage can accept a request this cycle (FIFO not full)
//   in_data     byte to be shifted
//   in_amt      right-shift amount, 0-7
//   sh_in       operand to the external shifter (FIFO head, 0 when empty)
//   sh_ctrl     shift amount to the external shifter (0 when empty)
//   sh_out      combinational result from the external shifter
//   out_valid   result register holds a valid result
//   out_ready   consumer accepts the result
//   out_data    registered shift result
//   out_lost    a '1' bit was shifted out of the captured result
//   fifo_count  current FIFO occupancy
// ---------------------------------------------------------------------------
module shift_req_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_amt,
    output logic [7:0]               sh_in,
    output logic [2:0]               sh_ctrl,
    input  logic [7:0]               sh_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_lost,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]    r_dataMem [DEPTH];
    logic [2:0]    r_amtMem  [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    // Output register
    logic          r_outValid;
    logic [7:0]    r_outData;

    // Control and datapath wires
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wrPtrNext;
    logic [PW-1:0] w_rdPtrNext;
    logic [7:0]    w_headData;
    logic [2:0]    w_headAmt;

    // -----------------------------------------------------------------------
    // Handshake decisions.
    // A full FIFO refuses a push even when a pop frees a slot in the same
    // cycle; this keeps in_ready a pure function of the registered count and
    // avoids a combinational path from out_ready to in_ready.
    // -----------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && (!r_outValid || out_ready);

    // Explicit wrap so the pointers stay correct for any depth value.
    always_comb begin
        w_wrPtrNext = (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + 1'b1;
        w_rdPtrNext = (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + 1'b1;
    end

    // Head entry drives the shifter; an empty FIFO presents a clean zero.
    always_comb begin
        w_headData = 8'h00;
        w_headAmt  = 3'd0;
        if (!w_empty) begin
            w_headData = r_dataMem[r_rdPtr];
            w_headAmt  = r_amtMem[r_rdPtr];
        end
    end

    assign sh_in   = w_headData;
    assign sh_ctrl = w_headAmt;

    // Storage is not reset: the pointers and count alone decide which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dataMem[r_wrPtr] <= in_data;
            r_amtMem[r_wrPtr]  <= in_amt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= w_wrPtrNext;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrNext;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign fifo_count = r_count;

    // -----------------------------------------------------------------------
    // Output register. A pop always refills it; otherwise a taken result
    // empties it. out_data is held while the consumer stalls and simply
    // keeps its last value after the result has been taken.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= 8'h00;
        end else if (w_pop) begin
            r_outValid <= 1'b1;
            r_outData  <= sh_out;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;

`ifdef SHIFT_REQ_LOST_BITS_EN
    // The bits that fall off a right shift by N are exactly data[N-1:0];
    // the mask is all zeros for N = 0, so nothing is ever lost there.
    logic [7:0] w_lostMask;
    logic       w_lostBit;
    logic       r_outLost;

    assign w_lostMask = ~(8'hFF << w_headAmt);
    assign w_lostBit  = |(w_headData & w_lostMask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outLost <= 1'b0;
        end else if (w_pop) begin
            r_outLost <= w_lostBit;
        end
    end

    assign out_lost = r_outLost;
`else
    assign out_lost = 1'b0;
`endif

endmodule

// File: tb/tb_shift_req_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_req_stage
//
// Directed and randomized checks for shift_req_stage. The bench plays the
// role of the external barrel shifter and keeps a queue-based reference
// model of the stage, checked after every clock edge and around resets.
// Compile with SHIFT_REQ_LOST_BITS_EN defined to exercise out_lost.
// ---------------------------------------------------------------------------
module tb_shift_req_stage;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic [2:0]             in_amt;
    logic [7:0]             sh_in;
    logic [2:0]             sh_ctrl;
    logic [7:0]             sh_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic                   out_lost;
    logic [$clog2(DEPTH):0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    shift_req_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .sh_in      (sh_in),
        .sh_ctrl    (sh_ctrl),
        .sh_out     (sh_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lost   (out_lost),
        .fifo_count (fifo_count)
    );

    // The downstream logical-right barrel shifter.
    assign sh_out = sh_in >> sh_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending requests in a queue, plus the result register.
    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
    } req_t;

    req_t       modelQ[$];
    logic       modelValid;
    logic [7:0] modelData;
    logic       modelLost;

    function automatic logic lostOf(input logic [7:0] d, input logic [2:0] a);
`ifdef SHIFT_REQ_LOST_BITS_EN
        int lowBits;
        lowBits = int'(d) % (1 << int'(a));
        return (lowBits != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelValid = 1'b0;
        modelData  = 8'h00;
        modelLost  = 1'b0;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [7:0] expShIn;
        logic [2:0] expShCtrl;
        expShIn   = (modelQ.size() > 0) ? modelQ[0].d : 8'h00;
        expShCtrl = (modelQ.size() > 0) ? modelQ[0].a : 3'd0;
        checkEq("in_ready",   32'(in_ready),   32'(modelQ.size() < DEPTH));
        checkEq("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
        checkEq("out_valid",  32'(out_valid),  32'(modelValid));
        checkEq("out_data",   32'(out_data),   32'(modelData));
        checkEq("out_lost",   32'(out_lost),   32'(modelLost));
        checkEq("sh_in",      32'(sh_in),      32'(expShIn));
        checkEq("sh_ctrl",    32'(sh_ctrl),    32'(expShCtrl));
    endtask

    // One clock cycle: drive inputs, predict from the model, step the edge,
    // advance the model, then check just after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic [2:0] a, input logic rdy);
        logic pushOk;
        logic popOk;
        req_t newReq;
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        out_ready = rdy;
        pushOk = v && (modelQ.size() < DEPTH);
        popOk  = (modelQ.size() > 0) && (!modelValid || rdy);
        @(posedge clk);
        if (popOk) begin
            modelValid = 1'b1;
            modelData  = modelQ[0].d >> modelQ[0].a;
            modelLost  = lostOf(modelQ[0].d, modelQ[0].a);
            void'(modelQ.pop_front());
        end else if (rdy) begin
            modelValid = 1'b0;
        end
        if (pushOk) begin
            newReq.d = d;
            newReq.a = a;
            modelQ.push_back(newReq);
        end
        #1;
        checkOutput();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        out_ready = 1'b0;
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;

        // Basic push B4 >> 2, two edges to a valid result
        applyStimulus(1'b1, 8'hB4, 3'd2, 1'b1);
        checkEq("b4_not_yet_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkEq("b4_valid", 32'(out_valid), 32'd1);
        checkEq("b4_data",  32'(out_data),  32'h2D);
        checkEq("b4_lost",  32'(out_lost),  32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);

        // 0F >> 3 loses three '1' bits
        applyStimulus(1'b1, 8'h0F, 3'd3, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkEq("0f_data", 32'(out_data), 32'h01);
`ifdef SHIFT_REQ_LOST_BITS_EN
        checkEq("0f_lost", 32'(out_lost), 32'd1);
`else
        checkEq("0f_lost", 32'(out_lost), 32'd0);
`endif
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);

        // Fill with the consumer stalled, including rejected extra requests
        for (int i = 0; i < DEPTH + 3; i++) begin
            applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'b0);
        end
        checkEq("full_count",    32'(fifo_count), 32'(DEPTH));
        checkEq("full_in_ready", 32'(in_ready),   32'd0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        end
        checkEq("drained_count", 32'(fifo_count), 32'd0);

        // Streaming: one result per cycle, amounts cycling 0..7
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'($urandom), 3'(i), 1'b1);
            if (i >= 1) begin
                checkEq("stream_valid", 32'(out_valid), 32'd1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 3'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        end

        // Asynchronous reset with three queued requests and a held result
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'b0);
        end
        checkEq("pre_rst_count", 32'(fifo_count), 32'd3);
        checkEq("pre_rst_valid", 32'(out_valid),  32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        modelReset();
        checkOutput();
        #2;
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        end

        // Traffic resumes cleanly after reset
        applyStimulus(1'b1, 8'h80, 3'd7, 1'b1);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
        checkEq("post_rst_data", 32'(out_data), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
